// File: rtl/blur_pkg.sv
// Shared types and constants for the 3x3 blur window sequencer.
package blur_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        STREAM,
        FLUSH,
        DONE
    } seq_state_t;

    localparam int KERNEL_SIZE   = 3;
    localparam int NUM_TAPS      = KERNEL_SIZE * KERNEL_SIZE;
    localparam int DEFAULT_PIX_W = 24;

    // Row (ky) and column (kx) positions inside the 3x3 neighbourhood.
    localparam int ROW_TOP   = 0;
    localparam int ROW_MID   = 1;
    localparam int ROW_BOT   = 2;
    localparam int COL_LEFT  = 0;
    localparam int COL_MID   = 1;
    localparam int COL_RIGHT = 2;

    function automatic int tap_index(input int ky, input int kx);
        return ky * KERNEL_SIZE + kx;
    endfunction

endpackage

// File: rtl/blur_line_buffer.sv
// One raster line of delay: tail is the pixel pushed DEPTH pushes ago.
module blur_line_buffer
    import blur_pkg::*;
#(
    parameter int DEPTH = 20,
    parameter int PIX_W = DEFAULT_PIX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [PIX_W-1:0] pixel,
    output logic [PIX_W-1:0] tail
);

    logic [PIX_W-1:0] mem [DEPTH];

    // NOTE: the storage is reset so a line never reads out stale X before it has filled;
    // this keeps the array in flops, which is fine for a line this short.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[0] <= pixel;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
        end
    end

    assign tail = mem[DEPTH-1];

endmodule

// File: rtl/blur_window_sequencer.sv
// Turns a raster pixel stream into zero-padded 3x3 windows, one per output pixel,
// with a flush of W+1 zero pushes to drain the last line.
module blur_window_sequencer
    import blur_pkg::*;
#(
    parameter int WIDTH  = 20,
    parameter int HEIGHT = 20,
    parameter int PIX_W  = DEFAULT_PIX_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PIX_W-1:0]          in_data,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic [NUM_TAPS*PIX_W-1:0] win_data,
    output logic                      win_border,
    output logic                      win_last,
    output logic                      busy,
    output logic                      done
);

    localparam int CNT_W = $clog2(WIDTH * HEIGHT + WIDTH + 2);

    localparam logic [CNT_W-1:0] FILL_END   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] STREAM_END = CNT_W'(WIDTH * HEIGHT - 1);
    localparam logic [CNT_W-1:0] PUSH_TOTAL = CNT_W'(WIDTH * HEIGHT + WIDTH + 1);
    localparam logic [CNT_W-1:0] WIN_FIRST  = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] COL_LAST   = CNT_W'(WIDTH - 1);

    seq_state_t state, state_next;

    logic [CNT_W-1:0] push_cnt;
    logic [CNT_W-1:0] out_row;
    logic [CNT_W-1:0] out_col;

    logic [PIX_W-1:0] taps      [KERNEL_SIZE][KERNEL_SIZE];
    logic [PIX_W-1:0] taps_next [KERNEL_SIZE][KERNEL_SIZE];
    logic [NUM_TAPS*PIX_W-1:0] win_next;

    logic [PIX_W-1:0] push_pixel;
    logic [PIX_W-1:0] line0_tail;
    logic [PIX_W-1:0] line1_tail;
    logic [KERNEL_SIZE-1:0] row_ok;
    logic [KERNEL_SIZE-1:0] col_ok;

    logic out_free;
    logic accepting;
    logic push;
    logic load;
    logic frame_start;
    logic last_accept;

    assign out_free    = !win_valid || win_ready;
    assign accepting   = (state == FILL) || (state == STREAM);
    assign in_ready    = accepting && out_free;
    assign push        = (accepting && in_valid && out_free)
                       || (state == FLUSH && out_free && push_cnt != PUSH_TOTAL);
    assign load        = push && (push_cnt >= WIN_FIRST);
    assign push_pixel  = (state == FLUSH) ? '0 : in_data;
    assign frame_start = start && (state == IDLE || state == DONE);
    assign last_accept = win_valid && win_ready && win_last;
    assign busy        = accepting || (state == FLUSH);
    assign done        = (state == DONE);

    blur_line_buffer #(.DEPTH(WIDTH), .PIX_W(PIX_W)) u_line0 (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pixel (push_pixel),
        .tail  (line0_tail)
    );

    blur_line_buffer #(.DEPTH(WIDTH), .PIX_W(PIX_W)) u_line1 (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pixel (line0_tail),
        .tail  (line1_tail)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every variable driven here gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FILL;
            FILL:    if (push && push_cnt == FILL_END) state_next = STREAM;
            STREAM:  if (push && push_cnt == STREAM_END) state_next = FLUSH;
            FLUSH:   if (push_cnt == PUSH_TOTAL && last_accept) state_next = DONE;
            DONE:    if (start) state_next = FILL;
            default: state_next = IDLE;
        endcase
    end

    // Padding masks are evaluated against the centre of the window being loaded.
    assign row_ok[ROW_TOP]   = (out_row != '0);
    assign row_ok[ROW_MID]   = 1'b1;
    assign row_ok[ROW_BOT]   = (out_row != ROW_LAST);
    assign col_ok[COL_LEFT]  = (out_col != '0);
    assign col_ok[COL_MID]   = 1'b1;
    assign col_ok[COL_RIGHT] = (out_col != COL_LAST);

    always_comb begin
        taps_next = taps;
        for (int ky = 0; ky < KERNEL_SIZE; ky++) begin
            taps_next[ky][COL_LEFT] = taps[ky][COL_MID];
            taps_next[ky][COL_MID]  = taps[ky][COL_RIGHT];
        end
        taps_next[ROW_TOP][COL_RIGHT] = line1_tail;
        taps_next[ROW_MID][COL_RIGHT] = line0_tail;
        taps_next[ROW_BOT][COL_RIGHT] = push_pixel;

        win_next = '0;
        for (int ky = 0; ky < KERNEL_SIZE; ky++) begin
            for (int kx = 0; kx < KERNEL_SIZE; kx++) begin
                if (row_ok[ky] && col_ok[kx])
                    win_next[tap_index(ky, kx)*PIX_W +: PIX_W] = taps_next[ky][kx];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_cnt   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            win_border <= 1'b0;
            win_last   <= 1'b0;
            for (int ky = 0; ky < KERNEL_SIZE; ky++)
                for (int kx = 0; kx < KERNEL_SIZE; kx++)
                    taps[ky][kx] <= '0;
        end else begin
            if (frame_start) begin
                push_cnt <= '0;
                out_row  <= '0;
                out_col  <= '0;
            end

            if (push) begin
                push_cnt <= push_cnt + 1'b1;
                taps     <= taps_next;
            end

            if (load) begin
                win_valid  <= 1'b1;
                win_data   <= win_next;
                win_border <= (out_row == '0) || (out_row == ROW_LAST)
                           || (out_col == '0) || (out_col == COL_LAST);
                win_last   <= (out_row == ROW_LAST) && (out_col == COL_LAST);
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blur_window_sequencer.sv
// Self-checking bench: directed frames plus randomized frames against a neighbourhood model.
module tb_blur_window_sequencer;

    localparam int W           = 4;
    localparam int H           = 3;
    localparam int PW          = 24;
    localparam int N           = W * H;
    localparam int WB          = 9 * PW;
    localparam int CYCLE_LIMIT = 2000;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          win_valid;
    logic          win_ready;
    logic [WB-1:0] win_data;
    logic          win_border;
    logic          win_last;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;
    int unsigned pix [N];

    always #5 clk = ~clk;

    blur_window_sequencer #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .win_border (win_border),
        .win_last   (win_last),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Zero-padded neighbourhood of raster index idx, straight from the frame array.
    function automatic logic [WB-1:0] exp_win(input int idx);
        logic [WB-1:0] w = '0;
        int r = idx / W;
        int c = idx % W;
        for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++) begin
                int rr = r + ky - 1;
                int cc = c + kx - 1;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                    w[(ky*3+kx)*PW +: PW] = PW'(pix[rr*W+cc]);
            end
        return w;
    endfunction

    function automatic logic [WB-1:0] pack9(input int t0, input int t1, input int t2,
                                            input int t3, input int t4, input int t5,
                                            input int t6, input int t7, input int t8);
        int t [9];
        logic [WB-1:0] w;
        t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3; t[4] = t4;
        t[5] = t5; t[6] = t6; t[7] = t7; t[8] = t8;
        for (int k = 0; k < 9; k++) w[k*PW +: PW] = PW'(t[k]);
        return w;
    endfunction

    // mode 0: full rate, pixel = index; mode 1: as 0 with a 4-cycle stall at centre (1,2);
    // mode 2: random pixels, random in_valid and win_ready.
    task automatic run_frame(input int mode, input int reset_at, input bit mid_start);
        int in_idx = 0;
        int win_idx = 0;
        int cycles = 0;
        int hold = 0;
        bit flush_ready = 1'b0;
        bit seen_first = 1'b0;
        bit start_done = 1'b0;
        int r, c;

        for (int i = 0; i < N; i++) pix[i] = (mode == 2) ? ($urandom & 32'h00FF_FFFF) : i;

        @(negedge clk);
        start = 1'b1; in_valid = 1'b0; win_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;

        while (win_idx < N && cycles < CYCLE_LIMIT) begin
            if (in_idx == reset_at) begin
                reset = 1'b1;
                in_valid = 1'b0;
                #1;
                check("abort_win_valid", win_valid, 0);
                check("abort_in_ready", in_ready, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_win_data", win_data, 0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            in_valid  = (in_idx < N) && (mode != 2 || $urandom_range(0, 3) != 0);
            in_data   = (in_idx < N) ? PW'(pix[in_idx]) : PW'($urandom);
            win_ready = (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (mode == 1 && win_valid && win_idx == 6 && hold < 4) begin
                win_ready = 1'b0;
                hold++;
            end
            start = mid_start && in_idx == 8 && !start_done;
            if (start) start_done = 1'b1;
            #1;
            if (win_valid) begin
                if (!seen_first) begin
                    seen_first = 1'b1;
                    check("first_win_after_pixels", in_idx, W + 2);
                end
                check("win_data", win_data, exp_win(win_idx));
                if (!win_ready) check("in_ready_stalled", in_ready, 0);
                if (win_ready) begin
                    r = win_idx / W;
                    c = win_idx % W;
                    check("win_border", win_border, (r == 0 || r == H-1 || c == 0 || c == W-1));
                    check("win_last", win_last, (win_idx == N-1));
                    if (mode != 2) begin
                        case (win_idx)
                            0:  check("taps_c00", win_data, pack9(0,0,0, 0,0,1, 0,4,5));
                            5:  check("taps_c11", win_data, pack9(0,1,2, 4,5,6, 8,9,10));
                            6:  check("taps_c12", win_data, pack9(1,2,3, 5,6,7, 9,10,11));
                            11: check("taps_c23", win_data, pack9(6,7,0, 10,11,0, 0,0,0));
                            default: ;
                        endcase
                    end
                    win_idx++;
                end
            end
            if (in_idx == N && busy && in_ready) flush_ready = 1'b1;
            if (in_valid && in_ready) in_idx++;
            cycles++;
            @(negedge clk);
        end

        start = 1'b0;
        in_valid = 1'b0;
        check("frame_windows", win_idx, N);
        if (mode == 1) check("stall_cycles", hold, 4);
        #1;
        check("flush_in_ready_low", flush_ready, 0);
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_win_valid", win_valid, 0);
        check("end_in_ready", in_ready, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; win_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_win_valid", win_valid, 0);
        check("rst_win_border", win_border, 0);
        check("rst_win_last", win_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_win_data", win_data, 0);
        @(negedge clk);
        reset = 1'b0;

        run_frame(0, -1, 1'b0);
        run_frame(1, -1, 1'b0);
        run_frame(0, 7, 1'b0);
        run_frame(0, -1, 1'b0);
        run_frame(0, -1, 1'b1);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = PW'($urandom);
            #1;
            check("done_in_ready", in_ready, 0);
            check("done_level", done, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("done_no_window", win_valid, 0);

        run_frame(0, -1, 1'b0);
        for (int f = 0; f < 4; f++) run_frame(2, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
